// File: rtl/qspi_phase_sequencer.sv
// ---------------------------------------------------------------------------
// qspi_phase_sequencer
//
// Walks one QSPI transfer through the CMD, ADDR, DUMMY and DATA phases. For
// each phase it runs the downstream cycle counter (start_count/target_count),
// waits for count_done, and inserts a one-cycle REARM gap so the counter can
// clear before the next run. The DATA phase is run once per byte.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   xfer_start      one-cycle transfer request (honoured only in IDLE)
//   xfer_abort      returns to IDLE on the next edge, no xfer_done
//   cmd_mode, addr_mode, data_mode
//                   lane mode per phase: 00 single, 01 dual, 1x quad
//   addr_en         address phase present
//   dummy_cycles    dummy phase length, 0 skips the phase
//   data_en         data phase present
//   data_len_m1     data bytes minus one
//   count_done      phase-complete pulse from the cycle counter
//   start_count     counter enable, high for the whole active phase
//   target_count    cycle count of the current (or, in REARM, next) run
//   cs_n            flash chip select, active low
//   busy            transfer in progress
//   phase           0 IDLE, 1 CMD, 2 ADDR, 3 DUMMY, 4 DATA, 5 REARM, 6 DONE
//   lane_mode       lane mode of the active phase (11 reported as 10)
//   byte_strobe     one-cycle pulse per completed data byte
//   xfer_done       one-cycle pulse at normal completion
// ---------------------------------------------------------------------------
module qspi_phase_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xfer_start,
  input  logic             xfer_abort,
  input  logic [1:0]       cmd_mode,
  input  logic [1:0]       addr_mode,
  input  logic [1:0]       data_mode,
  input  logic             addr_en,
  input  logic [4:0]       dummy_cycles,
  input  logic             data_en,
  input  logic [LEN_W-1:0] data_len_m1,
  input  logic             count_done,
  output logic             start_count,
  output logic [4:0]       target_count,
  output logic             cs_n,
  output logic             busy,
  output logic [2:0]       phase,
  output logic [1:0]       lane_mode,
  output logic             byte_strobe,
  output logic             xfer_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
    S_REARM = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [LEN_W:0] ONE_BYTE = {{LEN_W{1'b0}}, 1'b1};

  // Control state
  state_t         state;
  state_t         state_nxt;
  state_t         resume;
  state_t         resume_nxt;
  logic [4:0]     target_q;
  logic [4:0]     target_nxt;
  logic           strobe_q;
  logic           strobe_nxt;

  // Transfer configuration captured at start
  logic [1:0]     cmd_mode_q;
  logic [1:0]     addr_mode_q;
  logic [1:0]     data_mode_q;
  logic           addr_en_q;
  logic [4:0]     dummy_q;
  logic           data_en_q;
  logic [LEN_W:0] bytes_left;

  logic           active;
  logic           last_byte;
  state_t         follow;

  // Mode 11 is driven to the datapath as plain quad.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    norm_mode = (m == 2'b11) ? 2'b10 : m;
  endfunction

  // Counter cycles for one run of a phase: bits on the wire divided by lanes.
  function automatic logic [4:0] run_len(input state_t ph, input logic [1:0] m,
                                         input logic [4:0] dmy);
    logic [1:0] sh;
    logic [4:0] bits;
    sh   = (m == 2'b00) ? 2'd0 : (m == 2'b01) ? 2'd1 : 2'd2;
    bits = 5'd0;
    case (ph)
      S_CMD, S_DATA: bits = 5'd8;
      S_ADDR:        bits = 5'd24;
      default:       bits = 5'd0;
    endcase
    if (ph == S_DUMMY) begin
      run_len = dmy;
    end else begin
      run_len = bits >> sh;
    end
  endfunction

  // Phase that follows ph, skipping phases the configuration leaves out.
  function automatic state_t next_phase(input state_t ph, input logic a_en,
                                        input logic [4:0] dmy, input logic d_en,
                                        input logic last);
    next_phase = S_DONE;
    case (ph)
      S_CMD: begin
        if (a_en)              next_phase = S_ADDR;
        else if (dmy != 5'd0)  next_phase = S_DUMMY;
        else if (d_en)         next_phase = S_DATA;
      end
      S_ADDR: begin
        if (dmy != 5'd0)       next_phase = S_DUMMY;
        else if (d_en)         next_phase = S_DATA;
      end
      S_DUMMY: begin
        if (d_en)              next_phase = S_DATA;
      end
      S_DATA: begin
        if (!last)             next_phase = S_DATA;
      end
      default: next_phase = S_DONE;
    endcase
  endfunction

  // Lane mode shown while a phase is active; dummy cycles keep the address
  // lane setting so the bus turnaround matches the preceding phase.
  function automatic logic [1:0] mode_for(input state_t ph, input logic [1:0] cm,
                                          input logic [1:0] am, input logic [1:0] dm);
    case (ph)
      S_CMD:            mode_for = norm_mode(cm);
      S_ADDR, S_DUMMY:  mode_for = norm_mode(am);
      S_DATA:           mode_for = norm_mode(dm);
      default:          mode_for = 2'b00;
    endcase
  endfunction

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      resume   <= S_IDLE;
      target_q <= 5'd0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      resume   <= resume_nxt;
      target_q <= target_nxt;
      strobe_q <= strobe_nxt;
    end
  end

  // Configuration capture and byte countdown; meaningful only while state
  // says a transfer is running, so these carry no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && xfer_start) begin
      cmd_mode_q  <= cmd_mode;
      addr_mode_q <= addr_mode;
      data_mode_q <= data_mode;
      addr_en_q   <= addr_en;
      dummy_q     <= dummy_cycles;
      data_en_q   <= data_en;
      bytes_left  <= {1'b0, data_len_m1} + ONE_BYTE;
    end else if (state == S_DATA && count_done) begin
      bytes_left  <= bytes_left - ONE_BYTE;
    end
  end

  assign active    = (state == S_CMD) || (state == S_ADDR) ||
                     (state == S_DUMMY) || (state == S_DATA);
  assign last_byte = (bytes_left == ONE_BYTE);
  assign follow    = next_phase(state, addr_en_q, dummy_q, data_en_q, last_byte);

  // Next state and outputs
  always_comb begin
    state_nxt   = state;
    resume_nxt  = resume;
    target_nxt  = target_q;
    strobe_nxt  = 1'b0;

    start_count = active;
    target_count = target_q;
    cs_n        = 1'b1;
    busy        = 1'b0;
    phase       = state;
    lane_mode   = mode_for(state, cmd_mode_q, addr_mode_q, data_mode_q);
    byte_strobe = strobe_q;
    xfer_done   = (state == S_DONE);

    if (active || state == S_REARM) begin
      cs_n = 1'b0;
      busy = 1'b1;
    end

    case (state)
      S_IDLE: begin
        target_nxt = 5'd0;
        if (xfer_start) begin
          state_nxt  = S_CMD;
          target_nxt = run_len(S_CMD, cmd_mode, 5'd0);
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (count_done) begin
          // Target for the upcoming run is loaded on REARM entry.
          state_nxt  = S_REARM;
          resume_nxt = follow;
          strobe_nxt = (state == S_DATA);
          if (follow == S_DONE) begin
            target_nxt = 5'd0;
          end else begin
            target_nxt = run_len(follow,
                                 (follow == S_ADDR) ? addr_mode_q :
                                 (follow == S_DATA) ? data_mode_q : cmd_mode_q,
                                 dummy_q);
          end
        end
      end
      S_REARM: begin
        state_nxt = resume;
      end
      S_DONE: begin
        state_nxt  = S_IDLE;
        target_nxt = 5'd0;
      end
      default: begin
        state_nxt  = S_IDLE;
        target_nxt = 5'd0;
      end
    endcase

    if (xfer_abort) begin
      state_nxt  = S_IDLE;
      resume_nxt = S_IDLE;
      target_nxt = 5'd0;
      strobe_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_qspi_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_qspi_phase_sequencer
//
// Plays the role of the cycle counter: answers each start_count run with a
// count_done pulse after a random hold. The expected run list (phase, target,
// lane mode) is built from the transfer configuration with plain arithmetic
// and compared against what the sequencer presents.
// ---------------------------------------------------------------------------
module tb_qspi_phase_sequencer;

  localparam int LEN_W = 8;

  logic             clk;
  logic             rst;
  logic             xfer_start;
  logic             xfer_abort;
  logic [1:0]       cmd_mode;
  logic [1:0]       addr_mode;
  logic [1:0]       data_mode;
  logic             addr_en;
  logic [4:0]       dummy_cycles;
  logic             data_en;
  logic [LEN_W-1:0] data_len_m1;
  logic             count_done;
  logic             start_count;
  logic [4:0]       target_count;
  logic             cs_n;
  logic             busy;
  logic [2:0]       phase;
  logic [1:0]       lane_mode;
  logic             byte_strobe;
  logic             xfer_done;

  int vectors;
  int miscompares;

  qspi_phase_sequencer #(.LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .xfer_start   (xfer_start),
    .xfer_abort   (xfer_abort),
    .cmd_mode     (cmd_mode),
    .addr_mode    (addr_mode),
    .data_mode    (data_mode),
    .addr_en      (addr_en),
    .dummy_cycles (dummy_cycles),
    .data_en      (data_en),
    .data_len_m1  (data_len_m1),
    .count_done   (count_done),
    .start_count  (start_count),
    .target_count (target_count),
    .cs_n         (cs_n),
    .busy         (busy),
    .phase        (phase),
    .lane_mode    (lane_mode),
    .byte_strobe  (byte_strobe),
    .xfer_done    (xfer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are looked at 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".cs_n"},   32'(cs_n), 32'd1);
    chk({tag, ".start"},  32'(start_count), 32'd0);
    chk({tag, ".busy"},   32'(busy), 32'd0);
    chk({tag, ".phase"},  32'(phase), 32'd0);
    chk({tag, ".target"}, 32'(target_count), 32'd0);
    chk({tag, ".lane"},   32'(lane_mode), 32'd0);
    chk({tag, ".strobe"}, 32'(byte_strobe), 32'd0);
    chk({tag, ".done"},   32'(xfer_done), 32'd0);
  endtask

  function automatic int lanes(input logic [1:0] m);
    return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
  endfunction

  function automatic int shown_mode(input logic [1:0] m);
    return (m == 2'd3) ? 2 : int'(m);
  endfunction

  // Runs one full transfer and checks every phase against the expected list.
  task automatic run_xfer(input logic [1:0] cm, input logic [1:0] am,
                          input logic [1:0] dm, input logic ae,
                          input logic [4:0] dc, input logic de,
                          input logic [LEN_W-1:0] dl, input bit poke);
    int ph_q[$];
    int tg_q[$];
    int md_q[$];
    int n;
    int hold;

    ph_q.push_back(1); tg_q.push_back(8 / lanes(cm)); md_q.push_back(shown_mode(cm));
    if (ae) begin
      ph_q.push_back(2); tg_q.push_back(24 / lanes(am)); md_q.push_back(shown_mode(am));
    end
    if (dc != 5'd0) begin
      ph_q.push_back(3); tg_q.push_back(int'(dc)); md_q.push_back(-1);
    end
    if (de) begin
      for (int b = 0; b <= int'(dl); b++) begin
        ph_q.push_back(4); tg_q.push_back(8 / lanes(dm)); md_q.push_back(shown_mode(dm));
      end
    end
    n = ph_q.size();

    cmd_mode = cm; addr_mode = am; data_mode = dm; addr_en = ae;
    dummy_cycles = dc; data_en = de; data_len_m1 = dl;
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
    // Configuration churn during the transfer must not matter.
    cmd_mode = 2'($urandom); addr_mode = 2'($urandom); data_mode = 2'($urandom);
    addr_en = 1'($urandom); dummy_cycles = 5'($urandom); data_en = 1'($urandom);
    data_len_m1 = LEN_W'($urandom);

    for (int i = 0; i < n; i++) begin
      chk("act.phase",  32'(phase), 32'(ph_q[i]));
      chk("act.start",  32'(start_count), 32'd1);
      chk("act.target", 32'(target_count), 32'(tg_q[i]));
      chk("act.cs_n",   32'(cs_n), 32'd0);
      chk("act.busy",   32'(busy), 32'd1);
      chk("act.strobe", 32'(byte_strobe), 32'd0);
      if (md_q[i] >= 0) chk("act.lane", 32'(lane_mode), 32'(md_q[i]));
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        xfer_start = (poke && ph_q[i] == 4) ? 1'b1 : 1'b0;
        tick();
        xfer_start = 1'b0;
        chk("hold.phase",  32'(phase), 32'(ph_q[i]));
        chk("hold.target", 32'(target_count), 32'(tg_q[i]));
        chk("hold.start",  32'(start_count), 32'd1);
      end
      count_done = 1'b1;
      tick();
      count_done = 1'b0;
      chk("rearm.phase",  32'(phase), 32'd5);
      chk("rearm.start",  32'(start_count), 32'd0);
      chk("rearm.strobe", 32'(byte_strobe), 32'(ph_q[i] == 4));
      chk("rearm.cs_n",   32'(cs_n), 32'd0);
      chk("rearm.busy",   32'(busy), 32'd1);
      if (i + 1 < n) chk("rearm.target", 32'(target_count), 32'(tg_q[i + 1]));
      // Stray count_done outside an active phase is ignored.
      count_done = 1'($urandom);
      tick();
      count_done = 1'b0;
    end

    chk("done.phase",  32'(phase), 32'd6);
    chk("done.pulse",  32'(xfer_done), 32'd1);
    chk("done.busy",   32'(busy), 32'd0);
    chk("done.cs_n",   32'(cs_n), 32'd1);
    chk("done.start",  32'(start_count), 32'd0);
    chk("done.strobe", 32'(byte_strobe), 32'd0);
    count_done = 1'($urandom);
    tick();
    count_done = 1'b0;
    chk("post.phase", 32'(phase), 32'd0);
    chk("post.done",  32'(xfer_done), 32'd0);
    chk("post.cs_n",  32'(cs_n), 32'd1);
    chk("post.start", 32'(start_count), 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    xfer_start = 1'b0; xfer_abort = 1'b0; count_done = 1'b0;
    cmd_mode = 2'd0; addr_mode = 2'd0; data_mode = 2'd0;
    addr_en = 1'b0; dummy_cycles = 5'd0; data_en = 1'b0; data_len_m1 = '0;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("idle");

    // Single-mode read, two bytes, address, no dummy: 8, 24, 8, 8
    run_xfer(2'd0, 2'd0, 2'd0, 1'b1, 5'd0, 1'b1, 8'd1, 1'b0);
    // Quad data after command only
    run_xfer(2'd0, 2'd0, 2'd2, 1'b0, 5'd0, 1'b1, 8'd3, 1'b0);
    // Dual address then dummy, no data: 8, 12, 6
    run_xfer(2'd0, 2'd1, 2'd0, 1'b1, 5'd6, 1'b0, 8'd0, 1'b0);
    // xfer_start pulsed during DATA is ignored
    run_xfer(2'd1, 2'd1, 2'd1, 1'b1, 5'd3, 1'b1, 8'd2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_restart.phase", 32'(phase), 32'd0);
      chk("no_restart.start", 32'(start_count), 32'd0);
    end
    // Command only
    run_xfer(2'd2, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 8'd0, 1'b0);
    // Maximum length, mode 11, maximum dummy
    run_xfer(2'd3, 2'd3, 2'd3, 1'b1, 5'd31, 1'b1, 8'd255, 1'b0);

    for (int r = 0; r < 25; r++) begin
      run_xfer(2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
               5'($urandom_range(0, 9)), 1'($urandom),
               LEN_W'($urandom_range(0, 5)), 1'($urandom));
    end

    // Abort in ADDR coincident with count_done
    cmd_mode = 2'd0; addr_mode = 2'd0; data_mode = 2'd0; addr_en = 1'b1;
    dummy_cycles = 5'd0; data_en = 1'b1; data_len_m1 = 8'd0;
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
    chk("abort.cmd", 32'(phase), 32'd1);
    count_done = 1'b1;
    tick();
    count_done = 1'b0;
    tick();
    chk("abort.addr",   32'(phase), 32'd2);
    chk("abort.target", 32'(target_count), 32'd24);
    xfer_abort = 1'b1;
    count_done = 1'b1;
    tick();
    xfer_abort = 1'b0;
    count_done = 1'b0;
    chk_idle("abort");
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort.after_start", 32'(start_count), 32'd0);
      chk("abort.after_done",  32'(xfer_done), 32'd0);
      chk("abort.after_cs_n",  32'(cs_n), 32'd1);
    end

    // Abort beats a simultaneous start in IDLE
    xfer_abort = 1'b1;
    xfer_start = 1'b1;
    tick();
    xfer_abort = 1'b0;
    xfer_start = 1'b0;
    chk_idle("abort_vs_start");

    // Reset held for two cycles in the middle of DATA
    addr_en = 1'b0; dummy_cycles = 5'd0; data_en = 1'b1; data_mode = 2'd2;
    data_len_m1 = 8'd3;
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
    count_done = 1'b1;
    tick();
    count_done = 1'b0;
    tick();
    chk("rst_mid.data", 32'(phase), 32'd4);
    rst = 1'b1;
    tick();
    chk_idle("rst_mid");
    tick();
    rst = 1'b0;
    tick();
    chk_idle("rst_release");
    count_done = 1'b1;
    tick();
    count_done = 1'b0;
    chk_idle("stray_done_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qspi_phase_sequencer.md
# qspi_phase_sequencer

Transaction-level FSM that sits directly upstream of the QSPI cycle counter. It walks a QSPI transfer through command, address, dummy and data phases. For each phase it drives the counter's `start_count`/`target_count` and consumes `count_done`. It also produces chip-select, the current phase, lane mode and per-byte strobes for the shift datapath.

## Interface
Parameters:
- `LEN_W`, default 8: width of `data_len_m1`; data length is 1..2^LEN_W bytes.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `xfer_start`  in  1  one-cycle request; sampled only in IDLE.
- `xfer_abort`  in  1  terminates any transfer.
- `cmd_mode`, `addr_mode`, `data_mode`  in  2 each  lane mode per phase: 00 single, 01 dual, 10 quad, 11 treated as quad.
- `addr_en`  in  1  address phase present.
- `dummy_cycles`  in  5  dummy cycles, 0 = skip phase.
- `data_en`  in  1  data phase present.
- `data_len_m1`  in  LEN_W  data bytes minus one.
- `count_done`  in  1  phase-complete pulse from the cycle counter.
- `start_count`  out  1  counter enable, held high for the whole phase.
- `target_count`  out  5  cycles for the current counter run.
- `cs_n`  out  1  flash chip select, active low.
- `busy`  out  1  transfer in progress.
- `phase`  out  3  0 IDLE, 1 CMD, 2 ADDR, 3 DUMMY, 4 DATA, 5 REARM, 6 DONE.
- `lane_mode`  out  2  lane mode of the active phase.
- `byte_strobe`  out  1  one-cycle pulse per completed data byte.
- `xfer_done`  out  1  one-cycle pulse at normal completion.

## Operation
- **Reset values:** `cs_n`=1; `start_count`, `busy`, `byte_strobe` and `xfer_done` all 0; `target_count`=0; `phase`=IDLE; `lane_mode`=00.
- **Start:** on `xfer_start` in IDLE, latch all config inputs. Config changes during a transfer are ignored. Next state is CMD.
- **Target per phase** (width w = 1, 2 or 4 lanes):
  - CMD: 8/w.
  - ADDR: 24/w, giving 24, 12 or 6.
  - DUMMY: `dummy_cycles`.
  - DATA: 8/w per byte.
- **Active phases** (CMD, ADDR, DUMMY, DATA): hold `start_count`=1 and `target_count` constant, with `lane_mode` set from the latched mode for that phase. The phase ends on the cycle `count_done`=1 is sampled.
- **REARM:** after every `count_done`, one cycle with `start_count`=0. This lets the counter clear before the next run. During REARM, `target_count` is loaded with the next run's value.
- **Phase order:** CMD → ADDR (if `addr_en`) → DUMMY (if `dummy_cycles`≠0) → DATA (if `data_en`) → DONE. Skipped phases consume no cycles.
- **DATA phase:**
  - Internal byte counter is LEN_W+1 bits.
  - Each `count_done` pulses `byte_strobe` in the same cycle as REARM entry.
  - If bytes remain, return to DATA after REARM; otherwise go to DONE.
- **DONE:** one cycle with `xfer_done`=1, then IDLE. `cs_n` is released in DONE.
- **`xfer_abort`:** in any state, next cycle is IDLE with reset output values. No `xfer_done` is issued. Abort wins over a simultaneous `count_done` or `xfer_start`.
- **`xfer_start` outside IDLE:** ignored.
- **`count_done` outside active phases:** ignored.
- **Reset mid-transfer:** outputs take reset values on the next edge.

## Timing
- **Start latency:** `xfer_start` at cycle 0 → `phase`=CMD, `cs_n`=0, `busy`=1, `start_count`=1 at cycle 1.
- **During a transfer:** `cs_n`=0 and `busy`=1 from CMD entry through the last REARM. Both deassert in DONE.
- **`count_done` sampled at cycle t:**
  - `start_count`=0 and REARM at t+1.
  - Next active phase, with `start_count`=1, at t+2.
  - Or DONE at t+2.
- **Single-byte data phase:** `byte_strobe` asserts the cycle after the data `count_done`, and is never asserted for non-data phases.
- **`xfer_done`:** exactly one cycle. `busy` returns to 0 the same cycle; IDLE follows on the next cycle.

## Test plan
- **Reset check:** assert `rst` for 2 cycles mid-DATA → next cycle `cs_n`=1, `phase`=0, and every other output is 0.
- **Single-mode read, `data_len_m1`=1, no dummy:**
  - `target_count` sequence is 8, 24, 8, 8, with a one-cycle `start_count` gap after each `count_done`.
  - Exactly 2 `byte_strobe` pulses, then one `xfer_done`.
- **Quad data, command-only prefix** (`addr_en`=0, `dummy_cycles`=0, `data_len_m1`=3):
  - CMD target 8 in single mode, then DATA target 2 with `lane_mode`=10.
  - 4 strobes.
- **Dummy only** (`dummy_cycles`=6, `data_en`=0, `addr_en`=1 dual):
  - Targets are 8, 12, 6 → DONE.
  - `xfer_done` is a single pulse.
- **Abort** in ADDR, coincident with `count_done` → IDLE next cycle with `cs_n`=1, no `xfer_done`, no further `start_count`.
- **`xfer_start` pulsed during DATA** → ignored; the transfer completes unchanged and the next transfer needs a new start in IDLE.
